fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle fetch controller that owns the 16-bit program counter register and sequences instruction fetch, issue and next-PC selection for the single-issue core. It drives instruction memory through a request/ready handshake and presents each fetched instruction to decode with a valid/ready handshake. It then waits for the execute stage to resolve that instruction. On resolution it selects the next PC (sequential, taken branch or jump), retires the instruction and starts the next fetch. Exactly one instruction is in flight at a time.

## Interface
- RESET_VECTOR, 16'h0000, PC value loaded on reset (bit 0 must be 0)
- clock  in  1  processor clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  16  fetch address; equals pc while imem_req=1
- imem_ready  in  1  memory accepts request and returns imem_rdata this cycle
- imem_rdata  in  16  instruction word; valid when imem_req & imem_ready
- instr_valid  out  1  instr/instr_pc hold a fetched instruction for decode
- decode_ready  in  1  decode accepts instruction (handshake with instr_valid)
- instr  out  16  captured instruction word
- instr_pc  out  16  address of instr
- resolve_valid  in  1  execute has resolved the issued instruction
- flag_branch  in  1  instruction is a conditional branch
- aluZero  in  1  ALU zero result; branch taken = flag_branch & aluZero
- branchOff  in  16  signed byte offset (sign-extended, already shifted left 1)
- flag_jump  in  1  instruction is a jump
- jumpAddr  in  16  fully formed jump target
- halt_req  in  1  level; stop after current instruction resolves
- pc  out  16  architectural PC register
- halted  out  1  sequencer in HALT
- misalign_err  out  1  one-cycle pulse: selected target had bit 0 set
- retired  out  16  count of resolved instructions, wraps mod 2^16

## Operation
- States: FETCH, ISSUE, EXEC, HALT.
- Reset: pc=RESET_VECTOR, state=FETCH, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, misalign_err=0, retired=0.
  - imem_req is registered low during the reset cycle.
  - imem_req asserts in the first cycle after reset deasserts.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ready: instr<=imem_rdata, instr_pc<=pc, go to ISSUE.
  - Otherwise stay; imem_addr must remain stable.
- ISSUE: instr_valid=1; instr and instr_pc stable.
  - On decode_ready: go to EXEC.
- EXEC: instr_valid=0, imem_req=0. Wait for resolve_valid, then compute the target:
  - seq = instr_pc + 2
  - flag_jump=1: target = jumpAddr (jump wins even if a branch is also taken)
  - else if flag_branch & aluZero: target = seq + branchOff
  - else: target = seq
  - All arithmetic is 16-bit unsigned modulo 2^16; wrap-around is legal (16'hFFFE + 2 = 16'h0000).
  - If target[0]=1: pc<=target & 16'hFFFE and misalign_err pulses for 1 cycle.
- On resolve in EXEC: retired<=retired+1. Next state is HALT if halt_req=1, else FETCH.
- resolve_valid, flag_* and the target inputs are ignored outside EXEC.
- HALT: halted=1, imem_req=0, instr_valid=0; pc frozen. Only reset exits HALT.
- halt_req is sampled only at resolve in EXEC. It never aborts a pending fetch or issue.
- Reset mid-operation (any state) returns to the reset values on the next edge. A pending memory request is dropped, and the memory must tolerate an abandoned request.

## Timing
- All outputs are registered or decoded from state and registers only; there is no combinational path from any input to any output.
- Minimum 3 cycles per instruction: FETCH (ready same cycle) -> ISSUE (decode_ready same cycle) -> EXEC (resolve same cycle) -> FETCH with new pc.
- pc updates on the edge that leaves EXEC, and imem_addr shows the new pc in the following FETCH cycle.
- Memory wait states extend FETCH one cycle each. Decode stalls extend ISSUE one cycle each.
- misalign_err is high for exactly the cycle after the resolving edge.

## Test plan
- Sequential: RESET_VECTOR=0; imem_ready, decode_ready and resolve_valid held at 1 with no flags -> imem_addr sequence 0,2,4,6 at one fetch per 3 cycles; retired=3 after the third resolve.
- Taken branch: instr_pc=16'h0010, flag_branch=1, aluZero=1, branchOff=16'hFFF8 -> next imem_addr=16'h000A. With aluZero=0 -> 16'h0012.
- Jump priority: flag_jump=1, jumpAddr=16'h0400, flag_branch=aluZero=1 -> next imem_addr=16'h0400.
- Wrap and misalign: instr_pc=16'hFFFE sequential -> 16'h0000. jumpAddr=16'h0301 -> pc=16'h0300 and a one-cycle misalign_err pulse.
- Stalls: imem_ready low for 3 cycles, then decode_ready low for 2 cycles -> imem_addr and instr stable throughout; instr_valid high for exactly 3 cycles.
- Halt and reset: halt_req=1 at resolve -> halted=1, no further imem_req. Reset asserted in ISSUE -> next cycle instr_valid=0, pc=RESET_VECTOR, retired=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch/issue/resolve sequencer for a single-issue core: owns the PC, fetches one
// instruction at a time, hands it to decode and selects the next PC on resolution.
module fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    input  logic        decode_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        resolve_valid,
    input  logic        flag_branch,
    input  logic        aluZero,
    input  logic [15:0] branchOff,
    input  logic        flag_jump,
    input  logic [15:0] jumpAddr,
    input  logic        halt_req,
    output logic [15:0] pc,
    output logic        halted,
    output logic        misalign_err,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {FETCH, ISSUE, EXEC, HALT} state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, instr_reg, instr_pc_reg, retired_reg;
    logic        imem_req_reg, instr_valid_reg, halted_reg, misalign_reg;
    logic [15:0] seq_addr, target;
    logic        fetch_done, issue_done, resolve_done;

    // Acceptance is gated by the registered request so the reset-exit cycle
    // (state FETCH, request still low) can never capture a word.
    assign fetch_done   = (state_reg == FETCH) && imem_req_reg && imem_ready;
    assign issue_done   = (state_reg == ISSUE) && decode_ready;
    assign resolve_done = (state_reg == EXEC) && resolve_valid;

    always_comb begin
        seq_addr = instr_pc_reg + 16'd2;
        if (flag_jump)
            target = jumpAddr;
        else if (flag_branch && aluZero)
            target = seq_addr + branchOff;
        else
            target = seq_addr;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: if (fetch_done)   state_next = ISSUE;
            ISSUE: if (issue_done)   state_next = EXEC;
            EXEC:  if (resolve_done) state_next = halt_req ? HALT : FETCH;
            HALT:  state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_VECTOR;
            instr_reg       <= 16'h0000;
            instr_pc_reg    <= 16'h0000;
            retired_reg     <= 16'h0000;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b0;
            halted_reg      <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            imem_req_reg    <= (state_next == FETCH);
            instr_valid_reg <= (state_next == ISSUE);
            halted_reg      <= (state_next == HALT);
            misalign_reg    <= resolve_done && target[0];
            if (fetch_done) begin
                instr_reg    <= imem_rdata;
                instr_pc_reg <= pc_reg;
            end
            if (resolve_done) begin
                pc_reg      <= {target[15:1], 1'b0};
                retired_reg <= retired_reg + 16'd1;
            end
        end
    end

    assign imem_req     = imem_req_reg;
    assign imem_addr    = pc_reg;
    assign instr_valid  = instr_valid_reg;
    assign instr        = instr_reg;
    assign instr_pc     = instr_pc_reg;
    assign pc           = pc_reg;
    assign halted       = halted_reg;
    assign misalign_err = misalign_reg;
    assign retired      = retired_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one task per scenario, inline comparisons,
// instruction memory returns addr ^ 16'h5A5A with a controllable ready.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        decode_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        resolve_valid;
    logic        flag_branch;
    logic        aluZero;
    logic [15:0] branchOff;
    logic        flag_jump;
    logic [15:0] jumpAddr;
    logic        halt_req;
    logic [15:0] pc;
    logic        halted;
    logic        misalign_err;
    logic [15:0] retired;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    assign imem_rdata = imem_addr ^ 16'h5A5A;

    fetch_sequencer #(.RESET_VECTOR(16'h0000)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .decode_ready(decode_ready),
        .instr(instr), .instr_pc(instr_pc), .resolve_valid(resolve_valid),
        .flag_branch(flag_branch), .aluZero(aluZero), .branchOff(branchOff),
        .flag_jump(flag_jump), .jumpAddr(jumpAddr), .halt_req(halt_req),
        .pc(pc), .halted(halted), .misalign_err(misalign_err), .retired(retired)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From a FETCH cycle with all handshakes high, advance to the EXEC cycle.
    task automatic run_to_exec();
        tick();
        tick();
    endtask

    // Steer the PC with a jump instruction, then clear all flags.
    task automatic load_pc(input logic [15:0] addr);
        flag_jump = 1'b1;
        jumpAddr  = addr;
        run_to_exec();
        tick();
        flag_jump   = 1'b0;
        flag_branch = 1'b0;
        aluZero     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b1; decode_ready = 1'b1; resolve_valid = 1'b1;
        flag_branch = 1'b0; aluZero = 1'b0; branchOff = 16'h0000;
        flag_jump = 1'b0; jumpAddr = 16'h0000; halt_req = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({imem_req, instr_valid, halted, misalign_err} !== 4'b0000)
            $display("FAIL reset_ctrl: req/valid/halted/misalign=%b required 0000",
                     {imem_req, instr_valid, halted, misalign_err});
        else pass_cnt++;
        total_cnt++;
        if ({pc, instr, instr_pc, retired} !== 64'h0)
            $display("FAIL reset_regs: pc=%h instr=%h instr_pc=%h retired=%h required all 0000",
                     pc, instr, instr_pc, retired);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
            $display("FAIL reset_exit: req=%b addr=%h required 1/0000", imem_req, imem_addr);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        logic [15:0] exp_addr;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 16'(2 * i);
            total_cnt++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr)
                $display("FAIL seq_fetch%0d: req=%b addr=%h required 1/%h", i, imem_req, imem_addr, exp_addr);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (instr_valid !== 1'b1 || instr !== (exp_addr ^ 16'h5A5A) || instr_pc !== exp_addr)
                $display("FAIL seq_issue%0d: valid=%b instr=%h pc=%h required 1/%h/%h",
                         i, instr_valid, instr, instr_pc, exp_addr ^ 16'h5A5A, exp_addr);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (instr_valid !== 1'b0 || imem_req !== 1'b0)
                $display("FAIL seq_exec%0d: valid=%b req=%b required 0/0", i, instr_valid, imem_req);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (retired !== 16'd3 || imem_addr !== 16'h0006)
            $display("FAIL seq_retired: retired=%0d addr=%h required 3/0006", retired, imem_addr);
        else pass_cnt++;
        $display("test_sequential done");
    endtask

    task automatic test_branch();
        load_pc(16'h0010);
        flag_branch = 1'b1; aluZero = 1'b1; branchOff = 16'hFFF8;
        run_to_exec();
        total_cnt++;
        if (instr_pc !== 16'h0010)
            $display("FAIL br_instr_pc: got %h required 0010", instr_pc);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (imem_addr !== 16'h000A)
            $display("FAIL br_taken: addr=%h required 000A", imem_addr);
        else pass_cnt++;
        load_pc(16'h0010);
        flag_branch = 1'b1; aluZero = 1'b0;
        run_to_exec();
        tick();
        total_cnt++;
        if (imem_addr !== 16'h0012)
            $display("FAIL br_not_taken: addr=%h required 0012", imem_addr);
        else pass_cnt++;
        flag_branch = 1'b0;
        $display("test_branch done");
    endtask

    task automatic test_jump_priority();
        flag_jump = 1'b1; jumpAddr = 16'h0400;
        flag_branch = 1'b1; aluZero = 1'b1; branchOff = 16'hFFF8;
        run_to_exec();
        tick();
        total_cnt++;
        if (imem_addr !== 16'h0400)
            $display("FAIL jump_priority: addr=%h required 0400", imem_addr);
        else pass_cnt++;
        flag_jump = 1'b0; flag_branch = 1'b0; aluZero = 1'b0;
        $display("test_jump_priority done");
    endtask

    task automatic test_wrap_misalign();
        load_pc(16'hFFFE);
        run_to_exec();
        tick();
        total_cnt++;
        if (imem_addr !== 16'h0000 || misalign_err !== 1'b0)
            $display("FAIL wrap: addr=%h misalign=%b required 0000/0", imem_addr, misalign_err);
        else pass_cnt++;
        flag_jump = 1'b1; jumpAddr = 16'h0301;
        run_to_exec();
        total_cnt++;
        if (misalign_err !== 1'b0)
            $display("FAIL misalign_early: got %b required 0", misalign_err);
        else pass_cnt++;
        tick();
        flag_jump = 1'b0;
        total_cnt++;
        if (pc !== 16'h0300 || misalign_err !== 1'b1)
            $display("FAIL misalign_pulse: pc=%h misalign=%b required 0300/1", pc, misalign_err);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (misalign_err !== 1'b0)
            $display("FAIL misalign_width: got %b required 0", misalign_err);
        else pass_cnt++;
        tick();
        tick();
        $display("test_wrap_misalign done");
    endtask

    task automatic test_stalls();
        int valid_cycles = 0;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0302 || instr_valid !== 1'b0)
                $display("FAIL mem_stall%0d: req=%b addr=%h valid=%b required 1/0302/0",
                         i, imem_req, imem_addr, instr_valid);
            else pass_cnt++;
            tick();
        end
        imem_ready = 1'b1;
        decode_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) decode_ready = 1'b1;
            if (instr_valid === 1'b1) valid_cycles++;
            total_cnt++;
            if (instr !== 16'h5958 || instr_pc !== 16'h0302)
                $display("FAIL dec_stall%0d: instr=%h pc=%h required 5958/0302", i, instr, instr_pc);
            else pass_cnt++;
            tick();
        end
        if (instr_valid === 1'b1) valid_cycles++;
        total_cnt++;
        if (valid_cycles !== 3)
            $display("FAIL valid_width: valid cycles=%0d required 3", valid_cycles);
        else pass_cnt++;
        tick();
        $display("test_stalls done");
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        run_to_exec();
        total_cnt++;
        if (halted !== 1'b0)
            $display("FAIL halt_early: halted=%b required 0", halted);
        else pass_cnt++;
        tick();
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0306)
                $display("FAIL halt%0d: halted=%b req=%b valid=%b pc=%h required 1/0/0/0306",
                         i, halted, imem_req, instr_valid, pc);
            else pass_cnt++;
            tick();
        end
        $display("test_halt done");
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        load_pc(16'h0100);
        tick();
        total_cnt++;
        if (instr_valid !== 1'b1 || retired !== 16'd1 || pc !== 16'h0100)
            $display("FAIL pre_reset: valid=%b retired=%0d pc=%h required 1/1/0100",
                     instr_valid, retired, pc);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++;
        if (instr_valid !== 1'b0 || pc !== 16'h0000 || retired !== 16'd0 || imem_req !== 1'b0 || halted !== 1'b0)
            $display("FAIL mid_reset: valid=%b pc=%h retired=%0d req=%b halted=%b required 0/0000/0/0/0",
                     instr_valid, pc, retired, imem_req, halted);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
            $display("FAIL post_reset: req=%b addr=%h required 1/0000", imem_req, imem_addr);
        else pass_cnt++;
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_wrap_misalign();
        test_stalls();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
